// File: rtl/hs_mem_sfifo_ctrl.sv
// hs_mem_sfifo_ctrl: show-ahead synchronous FIFO controller that drives an
// external 1W/2R asynchronous-read RAM. This block owns the write/read
// pointers, the occupancy counter and the valid/ready handshakes. The RAM
// holds the payload, and its read port 1 supplies the head word directly.
module hs_mem_sfifo_ctrl #(
    parameter type DATA_TYPE    = logic [7:0],
    parameter int  DATA_DEPTH   = 16,
    parameter int  AFULL_THRESH = DATA_DEPTH - 2,
    localparam int ADDR_WIDTH   = $clog2(DATA_DEPTH),
    localparam int CNT_WIDTH    = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  DATA_TYPE              in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output DATA_TYPE              out_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  afull,
    output logic [ADDR_WIDTH-1:0] ram_wr0addr,
    output logic [ADDR_WIDTH-1:0] ram_r1addr,
    output DATA_TYPE              ram_wdata,
    output logic                  ram_wen,
    input  DATA_TYPE              ram_r1data
);

    // Parameter legality is checked once, at elaboration.
    if (DATA_DEPTH < 2) begin : g_bad_depth
        $error("hs_mem_sfifo_ctrl: DATA_DEPTH must be at least 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DATA_DEPTH) begin : g_bad_afull
        $error("hs_mem_sfifo_ctrl: AFULL_THRESH must lie in 1..DATA_DEPTH");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(DATA_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  AFULL_CNT = CNT_WIDTH'(AFULL_THRESH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  init_done;
    logic                  push;
    logic                  pop;

    // The depth need not be a power of two, so the wrap is an explicit
    // compare against the last slot instead of letting the pointer overflow.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr);
        return (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
    endfunction

    // Handshakes. Full and empty are judged on the registered count only.
    // A pop in the same cycle therefore frees no slot, and a push in the same
    // cycle makes no word visible. Flush suppresses both transfers.
    assign in_ready  = init_done && (cnt != FULL_CNT);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // RAM side. The head word is read combinationally at rptr (show-ahead).
    assign ram_wen     = push;
    assign ram_wdata   = in_data;
    assign ram_wr0addr = wptr;
    assign ram_r1addr  = rptr;
    assign out_data    = ram_r1data;

    assign count = cnt;
    assign afull = (cnt >= AFULL_CNT);

    // Hold off pushes until the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples pre-edge values no matter how the blocks are ordered.
        if (!rst_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    // Pointer and occupancy update. Flush overrides any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= next_addr(wptr);
            end
            if (pop) begin
                rptr <= next_addr(rptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_WIDTH'(1);
                2'b01:   cnt <= cnt - CNT_WIDTH'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_mem_sfifo_ctrl.sv
// Testbench for hs_mem_sfifo_ctrl with DATA_DEPTH=5 and the default
// AFULL_THRESH of 3. A simple RAM model sits behind the controller.
// Stimulus is directed first, then randomized. A negedge monitor checks every
// output against a queue-based reference FIFO. Expected head words are pushed
// into the queue on accepted pushes and popped on pops.
module tb_hs_mem_sfifo_ctrl;

    localparam int DEPTH = 5;
    localparam int AFULL = 3;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       afull;
    logic [2:0] ram_wr0addr;
    logic [2:0] ram_r1addr;
    logic [7:0] ram_wdata;
    logic       ram_wen;
    logic [7:0] ram_r1data;

    hs_mem_sfifo_ctrl #(
        .DATA_TYPE (logic [7:0]),
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .afull      (afull),
        .ram_wr0addr(ram_wr0addr),
        .ram_r1addr (ram_r1addr),
        .ram_wdata  (ram_wdata),
        .ram_wen    (ram_wen),
        .ram_r1data (ram_r1data)
    );

    // External RAM: synchronous write, asynchronous read.
    logic [7:0] mem [8];
    initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    always @(posedge clk) if (ram_wen) mem[ram_wr0addr] <= ram_wdata;
    assign ram_r1data = mem[ram_r1addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Reference model: the FIFO as a queue, plus slot indices that advance
    // modulo DEPTH for the expected RAM addresses.
    logic [7:0] exp_q[$];
    int         wr_idx    = 0;
    int         rd_idx    = 0;
    bit         init_seen = 1'b0;

    // Monitor: compares the outputs mid-cycle, then advances the model.
    always @(negedge clk) begin
        bit m_in_ready, m_push, m_pop;
        if (!rst_n) begin
            exp_q.delete();
            wr_idx    = 0;
            rd_idx    = 0;
            init_seen = 1'b0;
            check("rst_in_ready",  in_ready,    0);
            check("rst_out_valid", out_valid,   0);
            check("rst_count",     count,       0);
            check("rst_afull",     afull,       0);
            check("rst_wen",       ram_wen,     0);
            check("rst_wraddr",    ram_wr0addr, 0);
            check("rst_rdaddr",    ram_r1addr,  0);
        end else begin
            m_in_ready = init_seen && (exp_q.size() != DEPTH);
            m_push     = in_valid && m_in_ready && !flush;
            m_pop      = (exp_q.size() != 0) && out_ready && !flush;
            check("in_ready",  in_ready,  m_in_ready);
            check("out_valid", out_valid, exp_q.size() != 0);
            check("count",     count,     exp_q.size());
            check("afull",     afull,     exp_q.size() >= AFULL);
            check("ram_wen",   ram_wen,   m_push);
            check("wr_addr",   ram_wr0addr, wr_idx);
            check("rd_addr",   ram_r1addr,  rd_idx);
            if (m_push) check("ram_wdata", ram_wdata, in_data);
            if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
            if (flush) begin
                exp_q.delete();
                wr_idx = 0;
                rd_idx = 0;
            end else begin
                if (m_pop) begin
                    void'(exp_q.pop_front());
                    rd_idx = (rd_idx + 1) % DEPTH;
                end
                if (m_push) begin
                    exp_q.push_back(in_data);
                    wr_idx = (wr_idx + 1) % DEPTH;
                end
            end
            init_seen = 1'b1;
        end
    end

    // Applies one cycle of inputs just after the active edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic f);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        bit hold;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // Reset, then release. in_ready stays low through the release cycle.
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to capacity, then try to push into a full FIFO.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        repeat (2) drive(1'b1, 8'h16, 1'b0, 1'b0);
        // Push at full with a simultaneous pop: only the pop completes.
        drive(1'b1, 8'h16, 1'b1, 1'b0);
        // Drain the remainder, plus one idle cycle while empty.
        repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Keep two entries resident while streaming through the pointer wrap.
        drive(1'b1, 8'h20, 1'b0, 1'b0);
        drive(1'b1, 8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with a push pending, then push 0xAA and pop it.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b1);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes and one reset mid-run.
        // A stalled producer holds its word until it is accepted.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            hold = in_valid && !in_ready && rst_n;
            @(posedge clk);
            #1;
            if (!hold) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_data  = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 4);
            if (i == 200) begin
                #2;
                rst_n = 1'b0;
            end
            if (i == 202) rst_n = 1'b1;
        end

        repeat (8) drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
